// File: rtl/spi_peripheral_if.sv
// Bundle of SPI pins and decoder-side framing signals for spi_peripheral.
// The slave modport is the peripheral's view; master is the controller/decoder view.
interface spi_peripheral_if;
  logic        sck;
  logic        cs;
  logic        copi;
  logic        cipo;
  logic [7:0]  opcode;
  logic        opcode_valid;
  logic [7:0]  operand;
  logic        operand_valid;
  logic [15:0] operand_count;
  logic        response_request;
  logic [7:0]  response_data;
  logic        transaction_end;

  modport slave (
    input  sck, cs, copi, response_data,
    output cipo, opcode, opcode_valid, operand, operand_valid, operand_count,
           response_request, transaction_end
  );

  modport master (
    output sck, cs, copi, response_data,
    input  cipo, opcode, opcode_valid, operand, operand_valid, operand_count,
           response_request, transaction_end
  );
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 target: oversampled pins, opcode/operand byte framing, cipo response shifter.
// Optional macro SPI_PERIPHERAL_ID_READBACK_EN answers ID_OPCODE with CHIP_ID internally.
module spi_peripheral #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] ID_OPCODE   = 8'hDB,
  parameter logic [7:0] CHIP_ID     = 8'h81
) (
  input  logic             clk,
  input  logic             reset_n,
  spi_peripheral_if.slave  bus
);

`ifdef SPI_PERIPHERAL_ID_READBACK_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_OPCODE,
    ST_OPERAND
  } state_e;

  logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, copi_sync_q;
  logic                   sck_prev_q;
  logic                   sck_s, cs_s, copi_s, sck_rise, sck_fall;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        cipo_q, cipo_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        opcode_valid_q, opcode_valid_d;
  logic [7:0]  operand_q, operand_d;
  logic        operand_valid_q, operand_valid_d;
  logic [15:0] operand_count_q, operand_count_d;
  logic        load_pending_q, load_pending_d;
  logic        id_mode_q, id_mode_d;
  logic        transaction_end_q, transaction_end_d;
  logic        response_request;
  logic [7:0]  byte_in;
  logic [7:0]  load_byte;
  logic        id_hit;

  // Synchronisers reset low so WAIT_IDLE only leaves on a genuinely high cs.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      copi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], bus.copi};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign copi_s   = copi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  assign byte_in   = {rx_q[6:0], copi_s};
  assign id_hit    = ID_EN && (byte_in == ID_OPCODE);
  assign load_byte = id_mode_q ? CHIP_ID : bus.response_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d           = state_q;
    bit_cnt_d         = bit_cnt_q;
    rx_d              = rx_q;
    tx_d              = tx_q;
    cipo_d            = cipo_q;
    opcode_d          = opcode_q;
    opcode_valid_d    = 1'b0;
    operand_d         = operand_q;
    operand_valid_d   = 1'b0;
    operand_count_d   = operand_count_q;
    load_pending_d    = load_pending_q;
    id_mode_d         = id_mode_q;
    transaction_end_d = 1'b0;
    response_request  = 1'b0;

    // Count advances the cycle after the operand pulse so the pulse carries the 0-based index.
    if (operand_valid_q && (operand_count_q != 16'hFFFF)) begin
      operand_count_d = operand_count_q + 16'd1;
    end

    unique case (state_q)
      ST_WAIT_IDLE: begin
        if (cs_s) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        cipo_d = 1'b0;
        if (!cs_s) begin
          state_d        = ST_OPCODE;
          bit_cnt_d      = 3'd0;
          tx_d           = 8'h00;
          load_pending_d = 1'b0;
          id_mode_d      = 1'b0;
        end
      end

      ST_OPCODE, ST_OPERAND: begin
        // A cs rise wins over a coincident 8th sck rise: the partial byte is dropped.
        if (cs_s) begin
          state_d           = ST_IDLE;
          transaction_end_d = 1'b1;
          cipo_d            = 1'b0;
        end else if (sck_rise) begin
          rx_d      = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            load_pending_d = 1'b1;
            if (state_q == ST_OPCODE) begin
              state_d          = ST_OPERAND;
              opcode_d         = byte_in;
              opcode_valid_d   = 1'b1;
              operand_count_d  = 16'd0;
              id_mode_d        = id_hit;
              response_request = ~id_hit;
            end else begin
              operand_d        = byte_in;
              operand_valid_d  = 1'b1;
              response_request = ~id_mode_q;
            end
          end
        end else if (sck_fall) begin
          if (load_pending_q) begin
            tx_d           = load_byte;
            cipo_d         = load_byte[7];
            load_pending_d = 1'b0;
          end else begin
            tx_d   = {tx_q[6:0], 1'b0};
            cipo_d = tx_q[6];
          end
        end
      end

      default: state_d = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q           <= ST_WAIT_IDLE;
      bit_cnt_q         <= 3'd0;
      rx_q              <= 8'h00;
      tx_q              <= 8'h00;
      cipo_q            <= 1'b0;
      opcode_q          <= 8'h00;
      opcode_valid_q    <= 1'b0;
      operand_q         <= 8'h00;
      operand_valid_q   <= 1'b0;
      operand_count_q   <= 16'd0;
      load_pending_q    <= 1'b0;
      id_mode_q         <= 1'b0;
      transaction_end_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      bit_cnt_q         <= bit_cnt_d;
      rx_q              <= rx_d;
      tx_q              <= tx_d;
      cipo_q            <= cipo_d;
      opcode_q          <= opcode_d;
      opcode_valid_q    <= opcode_valid_d;
      operand_q         <= operand_d;
      operand_valid_q   <= operand_valid_d;
      operand_count_q   <= operand_count_d;
      load_pending_q    <= load_pending_d;
      id_mode_q         <= id_mode_d;
      transaction_end_q <= transaction_end_d;
    end
  end

  assign bus.cipo             = cipo_q;
  assign bus.opcode           = opcode_q;
  assign bus.opcode_valid     = opcode_valid_q;
  assign bus.operand          = operand_q;
  assign bus.operand_valid    = operand_valid_q;
  assign bus.operand_count    = operand_count_q;
  assign bus.response_request = response_request;
  assign bus.transaction_end  = transaction_end_q;

endmodule
